// File: rtl/viral_pkg.sv
// Shared constants for the ViRAL genome streamer: symbol width, ASCII base codes
// and the streaming FSM state type.
package viral_pkg;

  localparam int BYTE_WIDTH = 8;

  localparam logic [7:0] ASCII_A        = 8'h41;
  localparam logic [7:0] ASCII_C        = 8'h43;
  localparam logic [7:0] ASCII_G        = 8'h47;
  localparam logic [7:0] ASCII_T        = 8'h54;
  localparam logic [7:0] ASCII_N        = 8'h4E;
  localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  function automatic logic is_base(input logic [7:0] b);
    return (b == ASCII_A) || (b == ASCII_C) || (b == ASCII_G) ||
           (b == ASCII_T) || (b == ASCII_N);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rdata shows the head entry whenever
// empty is low. Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH      = 9,
  parameter int LOG2_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] PTR_ONE = {{LOG2_DEPTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [LOG2_DEPTH:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH:0] rd_ptr_q, rd_ptr_d;
  logic                do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[LOG2_DEPTH] != rd_ptr_q[LOG2_DEPTH]) &&
                   (wr_ptr_q[LOG2_DEPTH-1:0] == rd_ptr_q[LOG2_DEPTH-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[LOG2_DEPTH-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: a flush is just the pointers coming back together.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[LOG2_DEPTH-1:0]] <= wdata;
  end

endmodule

// File: rtl/genome_streamer.sv
// Buffers host ASCII bases and streams them to the ViRAL front end, one GAP cycle
// per genome end. Optional macro VIRAL_LOWERCASE_EN accepts lowercase bases.
module genome_streamer
  import viral_pkg::*;
#(
  parameter int BYTE            = BYTE_WIDTH,
  parameter int LOG2_FIFO_DEPTH = 4,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_valid,
  input  logic [BYTE-1:0]      i_data,
  input  logic                 i_last,
  output logic                 o_ready,
  input  logic                 i_rx_ready,
  output logic                 o_base_ready,
  output logic [BYTE-1:0]      o_base,
  output logic                 o_done,
  output logic [LEN_WIDTH-1:0] o_genome_count,
  output logic [LEN_WIDTH-1:0] o_last_len,
  output logic                 o_bad_base,
  output logic                 o_busy
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  logic            push, pop;
  logic            fifo_full, fifo_empty;
  logic [BYTE:0]   fifo_rdata;
  logic            pop_last;
  logic [BYTE-1:0] pop_byte;
  logic [7:0]      pop_low;
  logic            hi_zero;
  logic [BYTE-1:0] mapped_base;
  logic            mapped_bad;

  state_e                 state_q, state_d;
  logic [BYTE-1:0]        base_q, base_d;
  logic                   base_ready_q, base_ready_d;
  logic                   done_q, done_d;
  logic [LEN_WIDTH-1:0]   count_q, count_d;
  logic [LEN_WIDTH-1:0]   last_len_q, last_len_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic                   bad_q, bad_d;

  assign o_ready = rstn && !fifo_full;
  assign push    = i_valid && o_ready;

  sync_fifo #(
    .WIDTH      (BYTE + 1),
    .LOG2_DEPTH (LOG2_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata ({i_last, i_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop_last = fifo_rdata[BYTE];
  assign pop_byte = fifo_rdata[BYTE-1:0];
  assign pop_low  = pop_byte[7:0];
  assign hi_zero  = (pop_byte & ~BYTE'(8'hFF)) == '0;

  // Anything outside the base alphabet goes downstream as 'N' and is flagged.
  always_comb begin
    mapped_base = BYTE'(ASCII_N);
    mapped_bad  = 1'b1;
    if (hi_zero && is_base(pop_low)) begin
      mapped_base = pop_byte;
      mapped_bad  = 1'b0;
    end
`ifdef VIRAL_LOWERCASE_EN
    else if (hi_zero && pop_low[5] && is_base(pop_low & ~ASCII_CASE_BIT)) begin
      mapped_base = BYTE'(pop_low & ~ASCII_CASE_BIT);
      mapped_bad  = 1'b0;
    end
`endif
  end

  // Outputs are registered, so the GAP state shows up as o_done one cycle later,
  // right after the final base of the genome leaves.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    base_ready_d = 1'b0;
    done_d       = 1'b0;
    count_d      = count_q;
    last_len_d   = last_len_q;
    len_d        = len_q;
    bad_d        = bad_q;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (fifo_empty) begin
          state_d = ST_IDLE;
        end else if (i_rx_ready) begin
          pop          = 1'b1;
          base_d       = mapped_base;
          base_ready_d = 1'b1;
          bad_d        = bad_q | mapped_bad;
          if (len_q != '1) len_d = len_q + LEN_ONE;
          if (pop_last) state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        done_d     = 1'b1;
        count_d    = count_q + LEN_ONE;
        last_len_d = len_q;
        len_d      = '0;
        state_d    = fifo_empty ? ST_IDLE : ST_STREAM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      base_ready_q <= 1'b0;
      done_q       <= 1'b0;
      count_q      <= '0;
      last_len_q   <= '0;
      len_q        <= '0;
      bad_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      base_ready_q <= base_ready_d;
      done_q       <= done_d;
      count_q      <= count_d;
      last_len_q   <= last_len_d;
      len_q        <= len_d;
      bad_q        <= bad_d;
    end
  end

  assign o_base         = base_q;
  assign o_base_ready   = base_ready_q;
  assign o_done         = done_q;
  assign o_genome_count = count_q;
  assign o_last_len     = last_len_q;
  assign o_bad_base     = bad_q;
  assign o_busy         = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_genome_streamer.sv
// Scoreboard bench for genome_streamer: accepted host bytes feed a reference
// model whose expected bases and end-of-genome events are checked by a monitor.
module tb_genome_streamer;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        i_valid = 1'b0;
   logic [7:0]  i_data = 8'h00;
   logic        i_last = 1'b0;
   logic        o_ready;
   logic        i_rx_ready;
   logic        o_base_ready;
   logic [7:0]  o_base;
   logic        o_done;
   logic [15:0] o_genome_count;
   logic [15:0] o_last_len;
   logic        o_bad_base;
   logic        o_busy;

   genome_streamer #(
      .BYTE            (8),
      .LOG2_FIFO_DEPTH (4),
      .LEN_WIDTH       (16)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .i_valid        (i_valid),
      .i_data         (i_data),
      .i_last         (i_last),
      .o_ready        (o_ready),
      .i_rx_ready     (i_rx_ready),
      .o_base_ready   (o_base_ready),
      .o_base         (o_base),
      .o_done         (o_done),
      .o_genome_count (o_genome_count),
      .o_last_len     (o_last_len),
      .o_bad_base     (o_bad_base),
      .o_busy         (o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         isDone;
      logic [7:0] base;
      bit         last;
      bit         bad;
      int         count;
      int         len;
   } exp_t;

   exp_t       expQ[$];
   logic [8:0] stimQ[$];
   int         baseCycles[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         baseSeen = 0;
   int         doneSeen = 0;
   bit         monOn = 1'b0;
   bit         prevLast = 1'b0;
   bit         rxRand = 1'b0;
   bit         rxFixed = 1'b0;
   int         mLen = 0;
   int         mCount = 0;
   bit         mBad = 1'b0;

   // Cycle stamp for latency and back-to-back spacing checks.
   always @(posedge clk) cyc <= cyc + 1;

   // The receiver either holds a fixed ready level or flaps at random.
   always @(negedge clk) i_rx_ready = rxRand ? ($urandom_range(0, 3) != 0) : rxFixed;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Reference alphabet rule: legal uppercase passes, everything else becomes 'N'.
   function automatic void refMap(input logic [7:0] c, output logic [7:0] b, output bit bad);
      b   = "N";
      bad = 1'b1;
      case (c)
         "A", "C", "G", "T", "N": begin b = c; bad = 1'b0; end
`ifdef VIRAL_LOWERCASE_EN
         "a", "c", "g", "t", "n": begin b = c - 8'd32; bad = 1'b0; end
`endif
         default: ;
      endcase
   endfunction

   // Each accepted byte becomes one expected base; a last byte also queues its genome summary.
   task automatic modelAccept(input logic [7:0] d, input bit last);
      logic [7:0] b;
      bit         bad;
      exp_t       e;
      refMap(d, b, bad);
      mBad = mBad | bad;
      mLen++;
      e.isDone = 1'b0; e.base = b; e.last = last; e.bad = mBad; e.count = 0; e.len = 0;
      expQ.push_back(e);
      if (last) begin
         mCount   = (mCount + 1) % 65536;
         e.isDone = 1'b1; e.last = 1'b0; e.count = mCount; e.len = mLen;
         expQ.push_back(e);
         mLen = 0;
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a base or a done strobe.
   always @(negedge clk) begin
      exp_t e;
      if (monOn) begin
         if (prevLast) checkOutput("done_after_last", 32'(o_done), 32'd1);
         prevLast = 1'b0;
         if (o_done) checkOutput("no_base_in_gap", 32'(o_base_ready), 32'd0);
         if (o_base_ready) begin
            baseSeen++;
            baseCycles.push_back(cyc);
            if (expQ.size() == 0 || expQ[0].isDone) begin
               checks++; errors++;
               $display("[TB] FAIL unexpected_base: got %0h, no base pending (cycle %0d)", o_base, cyc);
            end else begin
               e = expQ.pop_front();
               checkOutput("base", 32'(o_base), 32'(e.base));
               checkOutput("bad_flag", 32'(o_bad_base), 32'(e.bad));
               prevLast = e.last;
            end
         end
         if (o_done) begin
            doneSeen++;
            if (expQ.size() == 0 || !expQ[0].isDone) begin
               checks++; errors++;
               $display("[TB] FAIL unexpected_done: got done=1, no genome end pending (cycle %0d)", cyc);
            end else begin
               e = expQ.pop_front();
               checkOutput("genome_count", 32'(o_genome_count), 32'(e.count));
               checkOutput("last_len", 32'(o_last_len), 32'(e.len));
               checkOutput("done_bad_flag", 32'(o_bad_base), 32'(e.bad));
            end
         end
      end
   end

   task automatic addGenome(input string s);
      for (int i = 0; i < s.len(); i++) stimQ.push_back({(i == s.len() - 1), s[i]});
   endtask

   task automatic pushByte(input logic [7:0] d, input bit last);
      int waited = 0;
      @(negedge clk);
      i_valid = 1'b1; i_data = d; i_last = last;
      while (!o_ready && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      if (!o_ready) begin
         checks++; errors++;
         $display("[TB] FAIL push_timeout: o_ready=0, expected 1 within 2000 cycles");
         i_valid = 1'b0;
      end else begin
         modelAccept(d, last);
         @(posedge clk);
      end
   endtask

   // Drives every queued byte, optionally with random idle cycles between them.
   task automatic applyStimulus(input int gapPct);
      logic [8:0] s;
      while (stimQ.size() != 0) begin
         s = stimQ.pop_front();
         pushByte(s[7:0], s[8]);
         if (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
            @(negedge clk);
            i_valid = 1'b0;
         end
      end
      @(negedge clk);
      i_valid = 1'b0; i_last = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (expQ.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (expQ.size() != 0) begin
         checks++; errors++;
         $display("[TB] FAIL drain_timeout: %0d items pending, expected 0", expQ.size());
         expQ.delete();
      end
      repeat (3) @(negedge clk);
      #1;
      checkOutput("busy_idle", 32'(o_busy), 32'd0);
   endtask

   task automatic applyReset();
      @(negedge clk);
      monOn = 1'b0; rstn = 1'b0; i_valid = 1'b0;
      expQ.delete(); mLen = 0; mCount = 0; mBad = 1'b0; prevLast = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1; monOn = 1'b1;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_base_ready"}, 32'(o_base_ready), 32'd0);
      checkOutput({tag, "_base"}, 32'(o_base), 32'd0);
      checkOutput({tag, "_done"}, 32'(o_done), 32'd0);
      checkOutput({tag, "_count"}, 32'(o_genome_count), 32'd0);
      checkOutput({tag, "_last_len"}, 32'(o_last_len), 32'd0);
      checkOutput({tag, "_bad"}, 32'(o_bad_base), 32'd0);
      checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
   endtask

   initial begin
      string legal = "ACGTN";
      string pool  = "ACGTNacgtnXZ0";
      int    seenBefore;
      int    doneBefore;
      int    n;

      // Reset state, including o_ready held low while rstn is asserted.
      rxFixed = 1'b1;
      repeat (3) @(negedge clk);
      checkResetState("reset");
      checkOutput("reset_o_ready", 32'(o_ready), 32'd0);
      rstn = 1'b1; monOn = 1'b1;

      // ACGT with the receiver always ready: four consecutive bases, then done.
      $display("[TB] directed ACGT");
      baseCycles.delete();
      addGenome("ACGT");
      applyStimulus(0);
      drain();
      checkOutput("acgt_count", 32'(o_genome_count), 32'd1);
      checkOutput("acgt_len", 32'(o_last_len), 32'd4);
      checkOutput("acgt_nbases", 32'(baseCycles.size()), 32'd4);
      if (baseCycles.size() >= 4)
         checkOutput("acgt_consecutive", 32'(baseCycles[3] - baseCycles[0]), 32'd3);

      // Fill the FIFO with the receiver stalled, then release it.
      $display("[TB] directed fill with receiver stalled");
      rxFixed = 1'b0;
      repeat (2) @(negedge clk);
      seenBefore = baseSeen;
      for (int i = 0; i < 16; i++) stimQ.push_back({(i == 15), legal[$urandom_range(0, 4)]});
      applyStimulus(0);
      #1;
      checkOutput("full_o_ready", 32'(o_ready), 32'd0);
      checkOutput("stall_no_output", 32'(baseSeen), 32'(seenBefore));
      checkOutput("stall_busy", 32'(o_busy), 32'd1);
      rxFixed = 1'b1;
      drain();
      checkOutput("fill_emitted", 32'(baseSeen - seenBefore), 32'd16);

      // Illegal base, and the sticky flag through the following genome.
      $display("[TB] directed illegal base");
      addGenome("AXG");
      applyStimulus(0);
      drain();
      checkOutput("axg_bad", 32'(o_bad_base), 32'd1);
      addGenome("CA");
      applyStimulus(0);
      drain();
      checkOutput("bad_sticky", 32'(o_bad_base), 32'd1);

      // Lowercase handling depends on the build option; the model knows which.
      $display("[TB] directed lowercase");
      applyReset();
      addGenome("acg");
      applyStimulus(0);
      drain();
      checkOutput("acg_bad", 32'(o_bad_base), 32'(mBad));

      // Back-to-back genomes of three and two bases.
      $display("[TB] directed back-to-back");
      applyReset();
      baseCycles.delete();
      doneBefore = doneSeen;
      addGenome("ACG");
      addGenome("TA");
      applyStimulus(0);
      drain();
      checkOutput("b2b_dones", 32'(doneSeen - doneBefore), 32'd2);
      checkOutput("b2b_count", 32'(o_genome_count), 32'd2);
      checkOutput("b2b_len", 32'(o_last_len), 32'd2);
      if (baseCycles.size() >= 5)
         checkOutput("b2b_single_gap", 32'(baseCycles[3] - baseCycles[2]), 32'd2);

      // Reset after two bases of a five-base genome.
      $display("[TB] directed mid-genome reset");
      rxFixed = 1'b0;
      repeat (2) @(negedge clk);
      seenBefore = baseSeen;
      addGenome("ACGTA");
      applyStimulus(0);
      rxFixed = 1'b1;
      n = 0;
      while (baseSeen < seenBefore + 2 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput("mid_two_bases", 32'(baseSeen - seenBefore), 32'd2);
      monOn = 1'b0; rstn = 1'b0;
      expQ.delete(); mLen = 0; mCount = 0; mBad = 1'b0; prevLast = 1'b0;
      @(negedge clk);
      checkResetState("midreset");
      rstn = 1'b1; monOn = 1'b1;
      doneBefore = doneSeen;
      repeat (8) @(negedge clk);
      checkOutput("midreset_no_done", 32'(doneSeen), 32'(doneBefore));

      // Random genomes, random host gaps and a flapping receiver.
      $display("[TB] random stress");
      rxRand = 1'b1;
      for (int g = 0; g < 25; g++) begin
         int len = $urandom_range(1, 10);
         for (int i = 0; i < len; i++) stimQ.push_back({(i == len - 1), pool[$urandom_range(0, 12)]});
         applyStimulus(30);
      end
      rxRand = 1'b0; rxFixed = 1'b1;
      drain();
      checkOutput("random_count", 32'(o_genome_count), 32'(mCount));
      checkOutput("random_bad", 32'(o_bad_base), 32'(mBad));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation still running, expected to finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/genome_streamer.md
GENOME_STREAMER -- requirements
Module: genome_streamer

Interface
REQ-001 Parameter BYTE, default 8: width of one base symbol in bits.
REQ-002 Parameter LOG2_FIFO_DEPTH, default 4: FIFO depth is 2**LOG2_FIFO_DEPTH entries.
REQ-003 Parameter LEN_WIDTH, default 16: width of the genome-length and genome-count counters.
REQ-004 Clock and reset: one clock; reset is synchronous and active-low.
REQ-005 Port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-006 Port rstn, input, 1: synchronous active-low reset.
REQ-007 Port i_valid, input, 1: host byte valid.
REQ-008 Port i_data, input, BYTE: host ASCII base.
REQ-009 Port i_last, input, 1: host byte is the final base of a genome.
REQ-010 Port o_ready, output, 1: streamer accepts a host byte this cycle.
REQ-011 Port i_rx_ready, input, 1: ViRAL front-end ready-to-receive.
REQ-012 Port o_base_ready, output, 1: o_base is valid this cycle.
REQ-013 Port o_base, output, BYTE: base driven to ViRAL.
REQ-014 Port o_done, output, 1: one-cycle end-of-genome strobe.
REQ-015 Port o_genome_count, output, LEN_WIDTH: number of genomes completed.
REQ-016 Port o_last_len, output, LEN_WIDTH: base count of the most recently completed genome.
REQ-017 Port o_bad_base, output, 1: sticky flag, set when an illegal base has been seen.
REQ-018 Port o_busy, output, 1: FIFO is non-empty or the FSM is not in IDLE.

Function
REQ-019 FIFO entries SHALL be {last, byte}; a push occurs when i_valid && o_ready; o_ready = !full, with no pass-through when full.
REQ-020 FSM states SHALL be IDLE, STREAM and GAP.
- IDLE -> STREAM when the FIFO is non-empty.
- STREAM -> GAP after popping an entry with last=1.
- STREAM -> IDLE when the FIFO is empty.
- GAP -> STREAM or IDLE (on FIFO empty) after exactly one cycle.
REQ-021 In STREAM, a pop SHALL occur when the FIFO is non-empty and i_rx_ready=1; o_base/o_base_ready are registered, so the popped byte appears with o_base_ready=1 on the next cycle (latency 1).
REQ-022 Cycles with no pop SHALL drive o_base_ready=0; o_base then holds its last value.
REQ-023 GAP SHALL drive o_base_ready=0 and o_done=1 for exactly one cycle, with no pop in that cycle; in the same edge, o_genome_count increments (wraps at 2**LEN_WIDTH) and o_last_len captures the genome length.
REQ-024 The length counter SHALL count forwarded bases of the current genome, saturate at all-ones, and clear on GAP.
REQ-025 Legal bases SHALL be ASCII 'A','C','G','T','N'; any other byte is forwarded as 'N' and sets o_bad_base.
REQ-026 If i_rx_ready falls mid-genome, the FSM SHALL stay in STREAM and drop no data.
REQ-027 A last entry popped while i_rx_ready then drops SHALL still produce GAP on the following cycle; o_done does not wait for i_rx_ready.
REQ-028 Simultaneous push and pop SHALL be allowed when the FIFO is non-full and non-empty; occupancy is unchanged.

Reset
REQ-029 With rstn=0 at a clock edge, the block SHALL reset as follows:
- FIFO flushed; FSM to IDLE.
- o_base_ready=0, o_base=0, o_done=0, o_genome_count=0, o_last_len=0, o_bad_base=0.
- o_busy=0; o_ready=0 during reset.
REQ-030 A reset mid-genome SHALL discard the partial genome and emit no o_done.

Configuration
REQ-031 With macro VIRAL_LOWERCASE_EN defined, lowercase 'a','c','g','t','n' SHALL be mapped to uppercase and not flagged.
REQ-032 Without VIRAL_LOWERCASE_EN, lowercase bases SHALL be treated as illegal (forwarded as 'N', o_bad_base set).

Structure
REQ-033 Shared package viral_pkg SHALL hold the BYTE constant, the ASCII base constants and the FSM state typedef.
REQ-034 The FIFO SHALL be sub-module sync_fifo (parameterised width and depth, full/empty outputs).

Verification
REQ-035 Stream "ACGT" (last on 'T') with i_rx_ready=1 -> o_base A,C,G,T on 4 consecutive cycles, then o_done=1 for 1 cycle, o_genome_count=1, o_last_len=4.
REQ-036 Hold i_rx_ready=0 while pushing 16 bytes -> o_ready=0 after 16 pushes, no o_base_ready; then raise i_rx_ready -> all 16 bytes emitted in order.
REQ-037 Push "AXG" -> o_base A,N,G; o_bad_base=1 and it stays 1 through the next genome.
REQ-038 Push "acg" -> with VIRAL_LOWERCASE_EN: A,C,G and o_bad_base=0; without: N,N,N and o_bad_base=1.
REQ-039 Two back-to-back genomes of lengths 3 and 2 -> exactly one o_done gap between them, o_genome_count=2, o_last_len=2.
REQ-040 Assert rstn=0 after 2 bases of a 5-base genome -> no o_done, all counters 0, o_busy=0 on the next cycle.
